// File: rtl/if_fetch_queue.sv
// Purpose : instruction-fetch front end; sequential PCs, pipelined imem requests, FETCH_DEPTH-entry queue to ID.
// Latency : a response becomes visible on id_valid the cycle after imem_resp_valid (registered queue, no bypass).
// Backpressure: credit-based; a request issues only if a queue slot is reserved for it, and id_ready stalls the queue head.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   redirect_valid / redirect_pc    EX-stage PC change; flushes the queue and squashes in-flight responses
//   imem_req_valid/ready/addr       request channel to instruction memory (addr = current fetch PC)
//   imem_resp_valid / imem_resp_data  in-order read responses, one per accepted request
//   id_valid / id_ready / id_inst / id_pc  queue head towards decode
//   outst_cnt                       number of requests awaiting a response
module if_fetch_queue #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     MEM_W       = 64,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(64'h8000_0000),
    parameter int unsigned     FETCH_DEPTH = 4,
    parameter int unsigned     MAX_OUTST   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic                           imem_req_valid,
    input  logic                           imem_req_ready,
    output logic [XLEN-1:0]                imem_req_addr,
    input  logic                           imem_resp_valid,
    input  logic [MEM_W-1:0]               imem_resp_data,
    output logic                           id_valid,
    input  logic                           id_ready,
    output logic [31:0]                    id_inst,
    output logic [XLEN-1:0]                id_pc,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt
);

    localparam int unsigned AW = $clog2(FETCH_DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned SW = AW + 2;   // wide enough for outst + q_count <= 2*FETCH_DEPTH

    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);
    localparam logic [SW-1:0] DEPTH_S = SW'(FETCH_DEPTH);

    // Fetch PC and request bookkeeping
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    // In-flight PC FIFO: one entry per accepted request, popped by each response
    logic [XLEN-1:0] pf_q [MAX_OUTST];
    logic [PW-1:0]   pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;

    // Instruction queue with one extra pointer bit for full/empty disambiguation
    logic [XLEN-1:0] q_pc_q   [FETCH_DEPTH];
    logic [31:0]     q_inst_q [FETCH_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     q_count;
    logic            q_empty, q_full;

    logic [SW-1:0]   credit_sum;
    logic            req_fire;
    logic            resp_keep;
    logic            q_push, q_pop;
    logic [XLEN-1:0] resp_pc;
    logic [31:0]     resp_inst;

    function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    assign q_count    = wr_ptr_q - rd_ptr_q;
    assign q_empty    = (wr_ptr_q == rd_ptr_q);
    assign q_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign credit_sum = SW'(outst_q) + SW'(q_count);

    // Every outstanding request owns a queue slot, so the queue can never overflow.
    // The request is held low during reset so nothing is presented before the first edge after release.
    assign imem_req_valid = !rst && !redirect_valid && (outst_q < MAX_C) && (credit_sum < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_pc = pf_q[pf_rd_q];

    if (MEM_W == 64) begin : g_sel64
        assign resp_inst = resp_pc[2] ? imem_resp_data[MEM_W-1:32] : imem_resp_data[31:0];
    end else begin : g_sel32
        assign resp_inst = imem_resp_data[31:0];
    end

    // A response landing in a redirect cycle belongs to the old stream and is squashed unconditionally.
    assign resp_keep = imem_resp_valid && !redirect_valid && (drop_q == '0);
    assign q_pop     = !q_empty && id_ready && !redirect_valid;
    assign q_push    = resp_keep && (!q_full || q_pop);

    assign id_valid  = !q_empty;
    assign id_inst   = q_inst_q[rd_ptr_q[AW-1:0]];
    assign id_pc     = q_pc_q[rd_ptr_q[AW-1:0]];
    assign outst_cnt = outst_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        outst_d = outst_q;
        case ({req_fire, imem_resp_valid})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        // Stale requests keep their credit; drop_cnt tracks how many of their responses to swallow.
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = outst_d;
        end else if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        pf_wr_d = req_fire        ? pf_inc(pf_wr_q) : pf_wr_q;
        pf_rd_d = imem_resp_valid ? pf_inc(pf_rd_q) : pf_rd_q;

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, q_push};
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, q_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            pf_wr_q    <= '0;
            pf_rd_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                pf_q[i] <= '0;
            end
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            pf_wr_q    <= pf_wr_d;
            pf_rd_q    <= pf_rd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (req_fire) begin
                pf_q[pf_wr_q] <= fetch_pc_q;
            end
            if (q_push) begin
                q_pc_q[wr_ptr_q[AW-1:0]]   <= resp_pc;
                q_inst_q[wr_ptr_q[AW-1:0]] <= resp_inst;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Purpose : randomized + directed bench for if_fetch_queue with an in-order variable-latency memory model.
// Latency : expected instructions are queued when the memory returns a live response; a monitor pops them on id handshakes.
// Backpressure: imem_req_ready and id_ready are randomized per cycle by the driver knobs.
module tb_if_fetch_queue;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic [1:0]  outst_cnt;

    if_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .outst_cnt       (outst_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] pc;
        bit          stale;
        int          due;
    } fl_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ex_t;

    fl_t         infl[$];
    ex_t         exq[$];
    logic [63:0] deliv_log[$];

    int n_total = 0;
    int n_bad   = 0;

    int          cyc = 0;
    logic [63:0] model_pc = RESET_PC;
    int unsigned lat_lo = 1, lat_hi = 1;
    int unsigned p_rdy = 100, p_idrdy = 100, p_redir = 0;
    bit          dir_redir = 0;
    logic [63:0] dir_pc = '0;
    bit          stall_prev = 0;
    logic [63:0] prev_addr = '0;
    int          n_fire = 0;
    int          max_outst = 0;
    logic [63:0] fire5_addr = '0;
    bit          redir_hit_resp = 0;
    int          n_deliv = 0;
    bit          prev_redir = 0;

    // Program image: two fixed words at RESET_PC, a distinct pattern everywhere else.
    function automatic logic [31:0] f_inst(input logic [63:0] pc);
        if (pc == 64'h8000_0000) return 32'h0010_0093;
        if (pc == 64'h8000_0004) return 32'h0000_0013;
        return pc[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] pc);
        logic [63:0] a;
        a = {pc[63:3], 3'b000};
        return {f_inst(a + 64'd4), f_inst(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus plus model update for the transfer happening at the next rising edge.
    task automatic cycle();
        int  pre_size;
        bit  fire;
        fl_t h;
        fl_t n;
        ex_t e;
        @(negedge clk);
        cyc++;
        if (infl.size() > 0 && cyc >= infl[0].due) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(infl[0].pc);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = {$urandom, $urandom};
        end
        if (dir_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = dir_pc;
            dir_redir      = 0;
        end else if ($urandom_range(99) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = RESET_PC + 64'($urandom_range(255) * 4);
        end else begin
            redirect_valid = 1'b0;
        end
        imem_req_ready = ($urandom_range(99) < p_rdy);
        id_ready       = ($urandom_range(99) < p_idrdy);
        #1;
        pre_size = infl.size();
        chk("outst_cnt", 64'(outst_cnt), 64'(pre_size));
        if (int'(outst_cnt) > max_outst) max_outst = int'(outst_cnt);
        if (redirect_valid) begin
            chk("no_req_on_redirect", 64'(imem_req_valid), 64'd0);
        end else if (stall_prev) begin
            chk("req_held_valid", 64'(imem_req_valid), 64'd1);
            chk("req_held_addr", imem_req_addr, prev_addr);
        end
        fire = imem_req_valid && imem_req_ready;
        if (imem_resp_valid) begin
            h = infl.pop_front();
            if (!h.stale && !redirect_valid) begin
                e.pc   = h.pc;
                e.inst = f_inst(h.pc);
                exq.push_back(e);
            end
        end
        if (redirect_valid) begin
            redir_hit_resp = imem_resp_valid && (pre_size == 2);
            foreach (infl[i]) infl[i].stale = 1;
            exq.delete();
            model_pc = redirect_pc;
        end
        if (fire) begin
            chk("req_addr", imem_req_addr, model_pc);
            if (n_fire == 4) fire5_addr = imem_req_addr;
            n_fire++;
            n.pc    = imem_req_addr;
            n.stale = 0;
            n.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
            infl.push_back(n);
            model_pc = model_pc + 64'd4;
        end
        stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr  = imem_req_addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        infl.delete();
        exq.delete();
        model_pc   = RESET_PC;
        stall_prev = 0;
        n_fire     = 0;
        max_outst  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every id handshake against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_redir = 0;
        end else begin
            if (prev_redir) chk("id_valid_after_redirect", 64'(id_valid), 64'd0);
            if (id_valid && id_ready && !redirect_valid) begin
                if (exq.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL id_unexpected: got pc %h inst %h, expected nothing", id_pc, id_inst);
                end else begin
                    ex_t e;
                    e = exq.pop_front();
                    chk("id_pc", id_pc, e.pc);
                    chk("id_inst", 64'(id_inst), 64'(e.inst));
                end
                deliv_log.push_back(id_pc);
                n_deliv++;
            end
            prev_redir = redirect_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int snap;
        int bad_range;
        int waited;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        #12;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_inst", 64'(id_inst), 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        chk("rst_outst", 64'(outst_cnt), 64'd0);

        // Stream at one instruction per cycle
        do_reset();
        p_rdy = 100; p_idrdy = 100; lat_lo = 1; lat_hi = 1; p_redir = 0;
        repeat (3) cycle();
        chk("t1_first_valid", 64'(id_valid), 64'd1);
        chk("t1_first_pc", id_pc, 64'h8000_0000);
        chk("t1_first_inst", 64'(id_inst), 64'h0010_0093);
        cycle();
        chk("t1_second_pc", id_pc, 64'h8000_0004);
        chk("t1_second_inst", 64'(id_inst), 64'h0000_0013);
        snap = n_deliv;
        repeat (20) cycle();
        chk("t1_throughput", 64'(n_deliv - snap), 64'd20);

        // Decode stalled: credits cap the number of requests at the queue depth
        do_reset();
        p_idrdy = 0;
        repeat (12) cycle();
        chk("t2_fire_count", 64'(n_fire), 64'd4);
        chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t2_outst", 64'(outst_cnt), 64'd0);
        chk("t2_id_valid", 64'(id_valid), 64'd1);
        p_idrdy = 100;
        repeat (6) cycle();
        chk("t2_resume_addr", fire5_addr, 64'h8000_0010);

        // Latency 3: outstanding count saturates at 2
        do_reset();
        lat_lo = 3; lat_hi = 3; p_idrdy = 80;
        repeat (60) cycle();
        chk("t3_max_outst", 64'(max_outst), 64'd2);

        // Redirect with two in flight and a response in the same cycle
        do_reset();
        lat_lo = 2; lat_hi = 2; p_idrdy = 100;
        repeat (2) cycle();
        dir_redir = 1; dir_pc = 64'h8000_0100;
        cycle();
        chk("t4_redirect_hit_resp", 64'(redir_hit_resp), 64'd1);
        deliv_log.delete();
        repeat (10) cycle();
        chk("t4_next_pc", (deliv_log.size() > 0) ? deliv_log[0] : 64'hdead, 64'h8000_0100);

        // Back-to-back redirects: the second one wins
        dir_redir = 1; dir_pc = 64'h8000_0200;
        cycle();
        dir_redir = 1; dir_pc = 64'h8000_0300;
        cycle();
        deliv_log.delete();
        repeat (15) cycle();
        bad_range = 0;
        foreach (deliv_log[i])
            if (deliv_log[i] >= 64'h8000_0200 && deliv_log[i] < 64'h8000_0300) bad_range++;
        chk("t5_no_stale_stream", 64'(bad_range), 64'd0);
        chk("t5_next_pc", (deliv_log.size() > 0) ? deliv_log[0] : 64'hdead, 64'h8000_0300);

        // Asynchronous reset with queued instructions and two requests in flight
        do_reset();
        p_idrdy = 0; lat_lo = 1; lat_hi = 1;
        repeat (2) cycle();
        lat_lo = 20; lat_hi = 20;
        repeat (3) cycle();
        chk("t6_pre_outst", 64'(outst_cnt), 64'd2);
        chk("t6_pre_id_valid", 64'(id_valid), 64'd1);
        @(posedge clk);
        #3;
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        #1;
        chk("t6_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_id_valid", 64'(id_valid), 64'd0);
        chk("t6_id_inst", 64'(id_inst), 64'd0);
        chk("t6_id_pc", id_pc, 64'd0);
        chk("t6_outst", 64'(outst_cnt), 64'd0);
        do_reset();
        p_idrdy = 100; lat_lo = 1; lat_hi = 1;
        repeat (6) cycle();
        chk("t6_restart_fires", 64'(n_fire > 0), 64'd1);

        // Randomized traffic with random redirects
        p_rdy = 70; p_idrdy = 60; lat_lo = 1; lat_hi = 4; p_redir = 4;
        repeat (400) cycle();

        // Drain: stop issuing, let everything in flight reach decode
        p_rdy = 0; p_idrdy = 100; p_redir = 0;
        waited = 0;
        while ((infl.size() != 0 || exq.size() != 0) && waited < 60) begin
            cycle();
            waited++;
        end
        repeat (2) cycle();
        chk("drain_scoreboard_empty", 64'(exq.size()), 64'd0);
        chk("drain_inflight_empty", 64'(infl.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
